// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, runs the imem req/ack handshake,
// keeps one skid entry for IF/ID stalls, and handles redirects. Option: FETCH_ALIGN_EXC_EN.
module if_fetch_ctrl #(
  parameter int             AW       = 32,
  parameter int             DW       = 32,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [5:0]    stall,
  input  logic          redirect_i,
  input  logic [AW-1:0] redirect_pc_i,
  output logic          imem_req_o,
  output logic [AW-1:0] imem_addr_o,
  input  logic          imem_ack_i,
  input  logic [DW-1:0] imem_rdata_i,
  output logic [AW-1:0] pc_o,
  output logic [DW-1:0] inst_o,
  output logic          inst_valid_o,
  output logic          stallreq_o,
  output logic [1:0]    fsm_state_o
`ifdef FETCH_ALIGN_EXC_EN
  , output logic        fetch_misalign_o
`endif
);

  // Handshake: imem_req_o/imem_addr_o hold stable from the first req cycle until
  // the cycle imem_ack_i is sampled high; imem_rdata_i is valid only in that cycle.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_READY = 2'd1, S_WAIT = 2'd2} state_e;

  localparam logic [AW-1:0] STEP = AW'(4);

  state_e        state_q, state_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] inst_q, inst_d;
  logic          inst_valid_q, inst_valid_d;
  logic [AW-1:0] skid_pc_q, skid_pc_d;
  logic [DW-1:0] skid_inst_q, skid_inst_d;
  logic          skid_valid_q, skid_valid_d;
  logic          kill_q, kill_d;
  logic [AW-1:0] redir_tgt;
  logic          parked;
  logic          start, in_req, ack_ok;
  logic          unused_stall;

  assign unused_stall = ^stall[5:2];

`ifdef FETCH_ALIGN_EXC_EN
  logic park_q, park_d, misalign_q, misalign_d;
  logic redir_bad;
  assign redir_tgt        = redirect_pc_i;
  assign redir_bad        = (redirect_pc_i[1:0] != 2'b00);
  assign parked           = park_q;
  assign fetch_misalign_o = misalign_q;
`else
  assign redir_tgt = {redirect_pc_i[AW-1:2], 2'b00};
  assign parked    = 1'b0;
`endif

  // A request may start in READY; the start cycle itself is a live req cycle.
  assign start       = (state_q == S_READY) & ~stall[0] & ~skid_valid_q & ~parked;
  assign in_req      = start | (state_q == S_WAIT);
  assign ack_ok      = in_req & imem_ack_i & ~kill_q & ~redirect_i;
  assign imem_req_o  = in_req;
  assign imem_addr_o = (state_q == S_WAIT) ? addr_q : fetch_pc_q;
  assign stallreq_o  = (state_q == S_WAIT) & ~imem_ack_i;
  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = inst_valid_q;
  assign fsm_state_o  = state_q;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    addr_d       = addr_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;
    skid_valid_d = skid_valid_q;
    kill_d       = kill_q;

    if (state_q == S_IDLE) state_d = S_READY;
    else                   state_d = (in_req & ~imem_ack_i) ? S_WAIT : S_READY;

    if (start) addr_d = fetch_pc_q;

    // The in-flight request is never dropped; a redirect only marks its data dead.
    if (in_req & imem_ack_i)     kill_d = 1'b0;
    else if (redirect_i & in_req) kill_d = 1'b1;

    if (redirect_i)  fetch_pc_d = redir_tgt;
    else if (ack_ok) fetch_pc_d = imem_addr_o + STEP;

    if (redirect_i) begin
      inst_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!stall[1]) begin
      if (skid_valid_q) begin
        pc_d         = skid_pc_q;
        inst_d       = skid_inst_q;
        inst_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (ack_ok) begin
        pc_d         = imem_addr_o;
        inst_d       = imem_rdata_i;
        inst_valid_d = 1'b1;
      end else begin
        inst_valid_d = 1'b0;
      end
    end else if (ack_ok) begin
      skid_pc_d    = imem_addr_o;
      skid_inst_d  = imem_rdata_i;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      fetch_pc_q   <= RESET_PC;
      addr_q       <= RESET_PC;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_inst_q  <= '0;
      skid_valid_q <= 1'b0;
      kill_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      addr_q       <= addr_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
      skid_valid_q <= skid_valid_d;
      kill_q       <= kill_d;
    end
  end

`ifdef FETCH_ALIGN_EXC_EN
  // A misaligned target parks the sequencer until a fresh redirect arrives.
  always_comb begin
    park_d     = redirect_i ? redir_bad : park_q;
    misalign_d = redirect_i & redir_bad;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      park_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      park_q     <= park_d;
      misalign_q <= misalign_d;
    end
  end
`endif

endmodule
